// File: rtl/apb_master_pkg.sv
// Shared APB definitions: requester FSM state encoding and default timeout.
package apb_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10,
      ST_RESP   = 2'b11
   } apb_state_e;

   localparam int unsigned APB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_master.sv
// APB requester: one command in flight, SETUP/ACCESS phases, wait-state
// timeout abort, and a held response until handshaken.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_strb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] padd,
   output logic [31:0] pwdata,
   output logic [3:0]  pstrb,
   input  logic        pready,
   input  logic [31:0] prdata,
   input  logic        pslverr
);

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   apb_state_e  r_state;
   logic [7:0]  r_wait;
   logic        r_cmd_ready;
   logic        r_psel;
   logic        r_penable;
   logic        r_pwrite;
   logic [31:0] r_padd;
   logic [31:0] r_pwdata;
   logic [3:0]  r_pstrb;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic        r_rsp_timeout;

   logic [7:0]  w_wait_nxt;
   logic        w_done;

   assign w_wait_nxt = r_wait + 8'd1;
   assign w_done     = r_psel & r_penable & pready;

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_wait        <= 8'd0;
         r_cmd_ready   <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_padd        <= 32'd0;
         r_pwdata      <= 32'd0;
         r_pstrb       <= 4'd0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= 32'd0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_psel      <= 1'b1;
                  r_pwrite    <= cmd_write;
                  r_padd      <= cmd_addr;
                  r_pwdata    <= cmd_wdata;
                  r_pstrb     <= cmd_write ? cmd_strb : 4'b0000;
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_wait    <= 8'd0;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // pready wins over a timeout reached on the same cycle
               if (w_done) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= r_pwrite ? 32'd0 : prdata;
                  r_rsp_err     <= pslverr;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= ST_RESP;
               end else begin
                  r_wait <= w_wait_nxt;
                  if (w_wait_nxt == TO_LIMIT) begin
                     r_psel        <= 1'b0;
                     r_penable     <= 1'b0;
                     r_rsp_valid   <= 1'b1;
                     r_rsp_rdata   <= 32'd0;
                     r_rsp_err     <= 1'b1;
                     r_rsp_timeout <= 1'b1;
                     r_state       <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign padd        = r_padd;
   assign pwdata      = r_pwdata;
   assign pstrb       = r_pstrb;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;

endmodule
